// File: rtl/countdown_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_anim_ctrl
// Purpose  : Countdown animation engine that sits upstream of the cube mode
//            FSM. While the FSM holds cda high, it counts START_DIGIT down
//            to 1. Each digit lasts TICKS_PER_STEP clocks. When the count
//            completes, the module raises cda_done and holds it until cda
//            is dropped.
// Ports    : clk        in  system clock
//            resetn     in  synchronous active-low reset
//            cda        in  countdown request level from mode FSM
//            cda_done   out countdown finished (level, held while cda=1)
//            busy       out high while loading or counting
//            digit      out [3:0] digit to render (0 when idle)
//            digit_vld  out renderer should draw digit
//            step_pulse out one-cycle pulse on every digit change
// Options  : COUNTDOWN_BLINK_EN - blank the digit during the second half of
//            each step (ports identical in both builds)
// Revision : 1.0 - initial release
// ============================================================================
module countdown_anim_ctrl #(
  parameter int TICKS_PER_STEP = 50_000_000,
  parameter int START_DIGIT    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cda,
  output logic       cda_done,
  output logic       busy,
  output logic [3:0] digit,
  output logic       digit_vld,
  output logic       step_pulse
);

  // Derived timer width; not intended to be overridden by the instantiator.
  localparam int TW = $clog2(TICKS_PER_STEP);

  localparam logic [TW-1:0] c_TIMER_MAX = TW'(TICKS_PER_STEP - 1);
  localparam logic [3:0]    c_START     = 4'(START_DIGIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state,  w_state_nxt;
  logic [TW-1:0] r_timer,  w_timer_nxt;
  logic [3:0]    r_digit,  w_digit_nxt;
  logic          r_pulse,  w_pulse_nxt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_digit <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_digit <= w_digit_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_digit_nxt = r_digit;
    w_pulse_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cda) w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        w_timer_nxt = '0;
        if (!cda) begin
          w_state_nxt = S_IDLE;
          w_digit_nxt = '0;
        end else begin
          w_state_nxt = S_COUNT;
          w_digit_nxt = c_START;
          w_pulse_nxt = 1'b1;
        end
      end

      S_COUNT: begin
        // The abort check comes first, so a drop of cda on the final tick
        // suppresses cda_done.
        if (!cda) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_digit_nxt = '0;
        end else if (r_timer == c_TIMER_MAX) begin
          w_timer_nxt = '0;
          if (r_digit > 4'd1) begin
            w_digit_nxt = r_digit - 4'd1;
            w_pulse_nxt = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
            w_digit_nxt = '0;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_DONE: begin
        if (!cda) w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        w_digit_nxt = '0;
      end
    endcase
  end

  assign cda_done   = (r_state == S_DONE);
  assign busy       = (r_state == S_LOAD) || (r_state == S_COUNT);
  assign digit      = r_digit;
  assign step_pulse = r_pulse;

`ifdef COUNTDOWN_BLINK_EN
  localparam logic [TW-1:0] c_TIMER_HALF = TW'(TICKS_PER_STEP / 2);
  // The digit is shown for the first half of each step only.
  assign digit_vld = (r_state == S_COUNT) && (r_timer < c_TIMER_HALF);
`else
  assign digit_vld = (r_state == S_COUNT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_countdown_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_anim_ctrl
// Purpose  : Scoreboard bench for countdown_anim_ctrl with TICKS_PER_STEP=4
//            and START_DIGIT=3. The stimulus process queues the output
//            expected after each clock edge. A monitor pops each entry and
//            compares it on the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_anim_ctrl;

  localparam int c_T = 4;
  localparam int c_S = 3;

  logic       clk;
  logic       resetn;
  logic       cda;
  logic       cda_done;
  logic       busy;
  logic [3:0] digit;
  logic       digit_vld;
  logic       step_pulse;

  countdown_anim_ctrl #(
    .TICKS_PER_STEP (c_T),
    .START_DIGIT    (c_S)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .cda        (cda),
    .cda_done   (cda_done),
    .busy       (busy),
    .digit      (digit),
    .digit_vld  (digit_vld),
    .step_pulse (step_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected vector layout: {cda_done, busy, digit_vld, step_pulse, digit[3:0]}
  typedef struct {
    logic [7:0] exp;
    string      tag;
  } item_t;

  item_t q[$];
  int    checks   = 0;
  int    failures = 0;

  localparam logic [7:0] c_IDLE = 8'b0000_0000;
  localparam logic [7:0] c_LOAD = 8'b0100_0000;
  localparam logic [7:0] c_DONE = 8'b1000_0000;

  // COUNT output for digit d shown on tick t (0..c_T-1) of its step.
  function automatic logic [7:0] cnt_exp(input int d, input int t);
    logic vld;
`ifdef COUNTDOWN_BLINK_EN
    vld = (t < c_T / 2);
`else
    vld = 1'b1;
`endif
    return {1'b0, 1'b1, vld, (t == 0), 4'(d)};
  endfunction

  // Monitor: compares one queued expectation per falling edge.
  initial begin
    item_t it;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {cda_done, busy, digit_vld, step_pulse, digit};
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got done/busy/vld/pulse/digit=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                   it.tag, act[7], act[6], act[5], act[4], act[3:0],
                   it.exp[7], it.exp[6], it.exp[5], it.exp[4], it.exp[3:0]);
        end
      end
    end
  end

  // Apply inputs for one edge and queue the output expected after it.
  task automatic cyc(input logic c, input logic rn, input logic [7:0] e, input string tag);
    item_t it;
    @(negedge clk);
    cda    = c;
    resetn = rn;
    @(posedge clk);
    it.exp = e;
    it.tag = tag;
    q.push_back(it);
  endtask

  // n consecutive COUNT cycles with cda held, starting from COUNT entry.
  task automatic count_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++)
      cyc(1'b1, 1'b1, cnt_exp(c_S - k / c_T, k % c_T), tag);
  endtask

  initial begin
    int guard;
    resetn = 1'b0;
    cda    = 1'b0;

    // Reset with cda high.
    cyc(1'b1, 1'b0, c_IDLE, "reset0");
    cyc(1'b1, 1'b0, c_IDLE, "reset1");
    cyc(1'b1, 1'b1, c_LOAD, "release_load");

    // Full countdown 3,3,3,3,2,...,1, then DONE held until cda drops.
    count_cycles(c_S * c_T, "full_count");
    cyc(1'b1, 1'b1, c_DONE, "done0");
    cyc(1'b1, 1'b1, c_DONE, "done1");
    cyc(1'b1, 1'b1, c_DONE, "done2");
    cyc(1'b0, 1'b1, c_IDLE, "done_drop");
    cyc(1'b0, 1'b1, c_IDLE, "idle_hold");

    // Abort while digit 2 is shown, then restart from 3.
    cyc(1'b1, 1'b1, c_LOAD, "abort_load");
    count_cycles(c_T + 2, "abort_count");
    cyc(1'b0, 1'b1, c_IDLE, "abort_idle");
    cyc(1'b0, 1'b1, c_IDLE, "abort_idle2");
    cyc(1'b1, 1'b1, c_LOAD, "restart_load");

    // Race: drop cda on the last tick of digit 1.
    count_cycles(c_S * c_T, "race_count");
    cyc(1'b0, 1'b1, c_IDLE, "race_idle");
    cyc(1'b0, 1'b1, c_IDLE, "race_idle2");

    // Abort directly from LOAD.
    cyc(1'b1, 1'b1, c_LOAD, "load_abort_load");
    cyc(1'b0, 1'b1, c_IDLE, "load_abort_idle");

    // Reset while digit 2 is shown.
    cyc(1'b1, 1'b1, c_LOAD, "rst_mid_load");
    count_cycles(c_T + 1, "rst_mid_count");
    cyc(1'b1, 1'b0, c_IDLE, "rst_mid_reset");
    cyc(1'b1, 1'b1, c_LOAD, "rst_mid_release");
    count_cycles(2, "rst_mid_restart");
    cyc(1'b0, 1'b1, c_IDLE, "final_idle");

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: queue entries left=%0d required 0", q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
